piso_serializer: RTL and testbench

Parallel-in, serial-out shift register: the transmit-side counterpart of the team's 4-bit serial-in shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, MSB first.
- A receiving SIPO that shifts into its LSB therefore reconstructs the word unchanged after WIDTH bits.
- Sits between a parallel producer (register/FIFO) and a 1-bit serial link.

---
 rtl/piso_serializer.sv | 87 ++++++++
 tb/tb_piso_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register: accepts a WIDTH-bit word over valid/ready, sends it MSB first.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_data_i,
  input  logic             p_valid_i,
  output logic             p_ready_o,
  input  logic             en_i,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             last_o,
  output logic             busy_o
);

`ifdef PISO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             at_last, accept, advance;

  assign busy_o    = (state == SHIFT);
  assign at_last   = busy_o && (cnt_p0 == CNT_LAST);
  assign last_o    = at_last;
  assign x_valid_o = busy_o;
  assign p_ready_o = (state == IDLE) || at_last;
  assign accept    = p_valid_i && p_ready_o && en_i;
  assign advance   = en_i && busy_o && !at_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (accept) state_nxt = SHIFT;
    end else if (en_i && at_last) begin
      state_nxt = p_valid_i ? SHIFT : IDLE;
    end
  end

  // Shift stage: load on accept, otherwise shift toward the MSB on each enabled non-final bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_p0 <= '0;
      cnt_p0   <= '0;
    end else if (accept) begin
      shreg_p0 <= p_data_i;
      cnt_p0   <= '0;
    end else if (advance) begin
      shreg_p0 <= shreg_p0 << 1;
      cnt_p0   <= cnt_p0 + CNT_W'(1);
    end
  end

`ifdef PISO_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  logic par_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      par_p0 <= 1'b0;
    else if (accept) par_p0 <= even_parity(p_data_i);
  end

  // The final frame slot carries the captured parity instead of shift-register data
  assign x_o = busy_o && (at_last ? par_p0 : shreg_p0[WIDTH-1]);
`else
  assign x_o = busy_o && shreg_p0[WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=4); covers reset, single word, streaming, stall, mid-frame reset, parity build.
module tb_piso_serializer;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] p_data_i;
  logic       p_valid_i;
  logic       p_ready_o;
  logic       en_i;
  logic       x_o;
  logic       x_valid_o;
  logic       last_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .p_data_i  (p_data_i),
    .p_valid_i (p_valid_i),
    .p_ready_o (p_ready_o),
    .en_i      (en_i),
    .x_o       (x_o),
    .x_valid_o (x_valid_o),
    .last_o    (last_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one serial bit slot: data, valid, last flag and ready flag
  task automatic chk_bit(input string tag, input logic xb, input logic lst, input logic rdy);
    chk({tag, ".x"},     {31'd0, x_o},       {31'd0, xb});
    chk({tag, ".xv"},    {31'd0, x_valid_o}, 32'd1);
    chk({tag, ".last"},  {31'd0, last_o},    {31'd0, lst});
    chk({tag, ".ready"}, {31'd0, p_ready_o}, {31'd0, rdy});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".x"},     {31'd0, x_o},       32'd0);
    chk({tag, ".xv"},    {31'd0, x_valid_o}, 32'd0);
    chk({tag, ".busy"},  {31'd0, busy_o},    32'd0);
    chk({tag, ".ready"}, {31'd0, p_ready_o}, 32'd1);
  endtask

  initial begin
    logic [7:0] seq;
    logic [4:0] pseq;

    // 1. Reset held with a pending word: nothing may start
    reset = 1'b0; p_valid_i = 1'b1; en_i = 1'b1; p_data_i = 4'hF;
    tick(); tick();
    chk_idle("rst_hold");
    en_i = 1'b0;
    reset = 1'b1;
    tick();
    chk_idle("rst_rel_noen");
    p_valid_i = 1'b0; en_i = 1'b1;
    tick();
    chk_idle("rst_rel_idle");

`ifndef PISO_PARITY_EN
    // 2. Single word 1011
    p_data_i = 4'b1011; p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0; p_data_i = 4'b0000;
    seq = 8'h0B;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("single%0d", i), seq[3-i], i == 3, i == 3);
      chk("single.busy", {31'd0, busy_o}, 32'd1);
      tick();
    end
    chk_idle("single_end");

    // 3. Back-to-back A then 5, no gap
    p_data_i = 4'hA; p_valid_i = 1'b1;
    tick();
    p_data_i = 4'h5;
    seq = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) p_valid_i = 1'b0;
      chk_bit($sformatf("b2b%0d", i), seq[7-i], (i == 3) || (i == 7), (i == 3) || (i == 7));
      tick();
    end
    chk_idle("b2b_end");

    // 4. Stall for 3 cycles after bit 2 of 1100; a pending word must not be taken mid-frame
    p_data_i = 4'b1100; p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    chk_bit("stall_b1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_bit("stall_b2", 1'b1, 1'b0, 1'b0);
    en_i = 1'b0; p_valid_i = 1'b1; p_data_i = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit($sformatf("stall_hold%0d", i), 1'b1, 1'b0, 1'b0);
    end
    en_i = 1'b1; p_valid_i = 1'b0;
    tick();
    chk_bit("stall_b3", 1'b0, 1'b0, 1'b0);
    tick();
    chk_bit("stall_b4", 1'b0, 1'b1, 1'b1);
    tick();
    chk_idle("stall_end");

    // 5. Async reset mid-frame of 1111, then a clean 0001 frame
    p_data_i = 4'b1111; p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    chk_bit("mrst_b1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_bit("mrst_b2", 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mrst_async.x",    {31'd0, x_o},       32'd0);
    chk("mrst_async.xv",   {31'd0, x_valid_o}, 32'd0);
    chk("mrst_async.busy", {31'd0, busy_o},    32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk_idle("mrst_after1");
    tick();
    chk_idle("mrst_after2");
    p_data_i = 4'b0001; p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    seq = 8'h01;
    for (int i = 0; i < 4; i++) begin
      chk_bit($sformatf("post%0d", i), seq[3-i], i == 3, i == 3);
      tick();
    end
    chk_idle("post_end");
`else
    // 6. Parity build: 1011 -> parity 1, 1001 -> parity 0
    p_data_i = 4'b1011; p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    pseq = 5'b10111;
    for (int i = 0; i < 5; i++) begin
      chk_bit($sformatf("par1_%0d", i), pseq[4-i], i == 4, i == 4);
      tick();
    end
    chk_idle("par1_end");
    p_data_i = 4'b1001; p_valid_i = 1'b1;
    tick();
    p_valid_i = 1'b0;
    pseq = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      chk_bit($sformatf("par2_%0d", i), pseq[4-i], i == 4, i == 4);
      tick();
    end
    chk_idle("par2_end");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
